pll_lock_sequencer: RTL and testbench

Sequences the video PLL wrapper from power-up to a qualified, stable output clock. Runs on the 50 MHz reference clock and drives the PLL's active-high `areset`. Samples the asynchronous `locked` output and holds downstream logic off until lock has been continuously stable. Retries bounded times on lock timeout, re-sequences automatically on lock loss, and reports a sticky failure when retries are exhausted.

---
 rtl/pll_lock_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer: drives areset, qualifies synchronized lock, retries on timeout.
// Optional saturating lock-loss counter enabled by defining PLL_SEQ_LOSS_COUNT_EN.
//
// state       | meaning
// S_RESET     | PLL areset held high for RST_CYCLES
// S_WAIT_LOCK | areset released, waiting for STABLE_CYCLES of continuous lock
// S_READY     | lock qualified, downstream released
// S_FAIL      | retries exhausted, areset held high until restart
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_restart,
  output logic       o_pll_rst,
  output logic       o_ready,
  output logic       o_fail,
  output logic [1:0] o_state,
  output logic [3:0] o_retries,
  output logic [7:0] o_loss_cnt
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMO_W = $clog2(LOCK_TIMEOUT);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_READY     = 2'd2,
    S_FAIL      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               lock_meta_q, lock_meta_d;
  logic               lock_s_q, lock_s_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [3:0]         retries_q, retries_d;
  logic               pll_rst_q, pll_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  always_comb begin
    lock_meta_d = i_locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retries_d   = retries_q;
    if (i_restart) begin
      state_d   = S_RESET;
      rst_cnt_d = RST_LOAD;
      retries_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == '0) begin
            state_d   = S_WAIT_LOCK;
            tmo_cnt_d = TMO_LOAD;
            stb_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          stb_cnt_d = lock_s_q ? stb_cnt_q + STB_W'(1) : '0;
          if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
          // qualification takes precedence over a coincident timeout
          if (lock_s_q && (stb_cnt_q == STB_LAST)) begin
            state_d   = S_READY;
            retries_d = '0;
          end else if (tmo_cnt_q == '0) begin
            if (retries_q < RETRY_MAX) begin
              state_d   = S_RESET;
              rst_cnt_d = RST_LOAD;
              retries_d = retries_q + 4'd1;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_READY: begin
          if (!lock_s_q) begin
            state_d   = S_RESET;
            rst_cnt_d = RST_LOAD;
          end
        end
        S_FAIL: ;
        default: state_d = S_RESET;
      endcase
    end
    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    ready_d   = (state_d == S_READY);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RESET;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      rst_cnt_q   <= RST_LOAD;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= pll_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign o_pll_rst = pll_rst_q;
  assign o_ready   = ready_q;
  assign o_fail    = fail_q;
  assign o_state   = state_q;
  assign o_retries = retries_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic       loss_evt;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_evt   = !i_restart && (state_q == S_READY) && !lock_s_q;
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) loss_cnt_q <= 8'd0;
    else          loss_cnt_q <= loss_cnt_d;
  end

  assign o_loss_cnt = loss_cnt_q;
`else
  assign o_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with randomized lock timing,
// expectations derived from event arithmetic (reset entry, lock rise, timeout periods).
module tb_pll_lock_sequencer;
  localparam int RST  = 4;
  localparam int STB  = 8;
  localparam int TMO  = 50;
  localparam int MAXR = 2;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, ready, fail;
  logic [1:0] state;
  logic [3:0] retries;
  logic [7:0] loss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_loss = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(RST), .STABLE_CYCLES(STB), .LOCK_TIMEOUT(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked), .i_restart(restart),
    .o_pll_rst(pll_rst), .o_ready(ready), .o_fail(fail), .o_state(state),
    .o_retries(retries), .o_loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int prst, input int rdy,
                         input int fl, input int ret);
    chk({tag, ".state"},   32'(state),    st);
    chk({tag, ".pll_rst"}, 32'(pll_rst),  prst);
    chk({tag, ".ready"},   32'(ready),    rdy);
    chk({tag, ".fail"},    32'(fail),     fl);
    chk({tag, ".retries"}, 32'(retries),  ret);
    chk({tag, ".loss"},    32'(loss_cnt), exp_loss);
  endtask

  // One lock attempt from a RESET entry at edge e0. locked rises after edge r1; if hi>0 it
  // drops after hi cycles for lo cycles and rises again. Only the last unbroken run qualifies,
  // and it only counts once the FSM is in WAIT_LOCK.
  task automatic lock_attempt(input string tag, input int e0, input int r1, input int hi,
                              input int lo, input int ret0);
    int r, ws, first, rdy;
    r     = (hi == 0) ? r1 : r1 + hi + lo;
    ws    = e0 + RST;
    first = (r + 3 > ws + 1) ? r + 3 : ws + 1;
    rdy   = first + STB - 1;
    while (cyc < rdy + 2) begin
      if (cyc == r1) locked = 1'b1;
      if (hi != 0 && cyc == r1 + hi) locked = 1'b0;
      if (hi != 0 && cyc == r) locked = 1'b1;
      tick();
      chk_all(tag, (cyc < ws) ? 0 : ((cyc < rdy) ? 1 : 2), int'(cyc < ws), int'(cyc >= rdy), 0,
              (cyc < rdy) ? ret0 : 0);
    end
  endtask

  task automatic lose_lock(input string tag);
    int c;
    c = cyc;
    locked = 1'b0;
    repeat (3) begin
      tick();
      if (cyc == c + 3 && exp_loss < 255) exp_loss += LOSS_EN;
      chk_all(tag, (cyc < c + 3) ? 2 : 0, int'(cyc >= c + 3), int'(cyc < c + 3), 0, 0);
    end
  endtask

  initial begin
    int e0, d, a, ph, per, r1, hi, lo;
    per = RST + TMO;

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    cyc = 0;
    chk_all("release", 0, 1, 0, 0, 0);

    lock_attempt("nominal", 0, 10, 0, 0, 0);
    lose_lock("loss1");

    r1 = cyc + int'($urandom_range(0, 20));
    lock_attempt("glitch", cyc, r1, 5, 1, 0);
    lose_lock("loss2");

    e0 = cyc;
    while (cyc < e0 + (MAXR + 1) * per + 5) begin
      tick();
      d  = cyc - e0;
      a  = d / per;
      ph = d % per;
      if (a > MAXR) chk_all("nolock", 3, 1, 0, 1, MAXR);
      else          chk_all("nolock", (ph < RST) ? 0 : 1, int'(ph < RST), 0, 0, a);
    end

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_all("restart", 0, 1, 0, 0, 0);
    hi = int'($urandom_range(0, 7));
    lo = int'($urandom_range(1, 3));
    r1 = cyc + int'($urandom_range(0, 15));
    lock_attempt("relock", cyc, r1, hi, lo, 0);

    lose_lock("loss3");
    repeat (6) tick();
    chk_all("pre_arst", 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    exp_loss = 0;
    #1;
    chk_all("arst", 0, 1, 0, 0, 0);
    locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    lock_attempt("post_arst", 0, int'($urandom_range(2, 20)), 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
